// File: rtl/flag_branch_unit.sv
// flag_branch_unit: architectural Z/V/N flag register with per-opcode update
// masks, branch condition resolution against forwarded next-state flags, a
// multi-cycle front-end flush sequence on taken branches, and saturating
// branch/taken statistics counters.
module flag_branch_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,  // 1..15
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             ex_setflags,
  input  logic [2:0]       ex_ALUop,
  input  logic             ov,
  input  logic             zr,
  input  logic             neg,
  input  logic             br_valid,
  input  logic [2:0]       br_ccc,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n,
  output logic             br_taken,
  output logic             flush,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_e             state_q, state_d;
  logic [3:0]         fcnt_q, fcnt_d;
  logic               flag_z_q, flag_z_d;
  logic               flag_v_q, flag_v_d;
  logic               flag_n_q, flag_n_d;
  logic               br_taken_q, br_taken_d;
  logic               flush_q, flush_d;
  logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]   taken_cnt_q, taken_cnt_d;
  logic               upd_all, upd_z;
  logic               cond;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Flag next-state: opcode selects which flags the EX instruction may write;
  // wrong-path instructions (during FLUSH) never touch the flags.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    upd_all = 1'b0;
    upd_z   = 1'b0;
    if (ex_valid && ex_setflags && !stall && (state_q == S_IDLE)) begin
      unique case (ex_ALUop)
        3'b000, 3'b010: upd_all = 1'b1;  // ADD, SUB: Z, V, N
        3'b001:         ;                // PADDSB: no flag change
        default:        upd_z   = 1'b1;  // logical / shifts: Z only
      endcase
    end
    flag_z_d = (upd_all || upd_z) ? zr  : flag_z_q;
    flag_v_d = upd_all            ? ov  : flag_v_q;
    flag_n_d = upd_all            ? neg : flag_n_q;
  end

  // Branch condition, evaluated on the forwarded (next-state) flags so a
  // flag-setting instruction in EX is visible to the branch in decode.
  always_comb begin
    unique case (br_ccc)
      3'b000:  cond = !flag_z_d;                 // NEQ
      3'b001:  cond = flag_z_d;                  // EQ
      3'b010:  cond = !flag_z_d && !flag_n_d;    // GT
      3'b011:  cond = flag_n_d;                  // LT
      3'b100:  cond = flag_z_d || !flag_n_d;     // GTE
      3'b101:  cond = flag_n_d || flag_z_d;      // LTE
      3'b110:  cond = flag_v_d;                  // OVF
      default: cond = 1'b1;                      // UNCOND
    endcase
  end

  // Branch / flush FSM next-state; stall freezes everything except the
  // single-cycle br_taken pulse, which always drops.
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    br_taken_d  = 1'b0;
    flush_d     = flush_q;
    br_cnt_d    = br_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (!stall) begin
      unique case (state_q)
        S_IDLE: begin
          if (br_valid) begin
            br_cnt_d = sat_inc(br_cnt_q);
            if (cond) begin
              taken_cnt_d = sat_inc(taken_cnt_q);
              br_taken_d  = 1'b1;
              fcnt_d      = FLUSH_LOAD;
              flush_d     = 1'b1;
              state_d     = S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          // br_valid here belongs to a wrong-path instruction: ignored.
          fcnt_d = fcnt_q - 4'd1;
          if (fcnt_q == 4'd1) begin
            flush_d = 1'b0;
            state_d = S_IDLE;
          end
        end
      endcase
    end
  end

  // All state registers; asynchronous reset returns to IDLE from anywhere.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before the edge, independent of statement order.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      fcnt_q      <= 4'd0;
      flag_z_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      br_taken_q  <= 1'b0;
      flush_q     <= 1'b0;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      flag_z_q    <= flag_z_d;
      flag_v_q    <= flag_v_d;
      flag_n_q    <= flag_n_d;
      br_taken_q  <= br_taken_d;
      flush_q     <= flush_d;
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign flag_z      = flag_z_q;
  assign flag_v      = flag_v_q;
  assign flag_n      = flag_n_q;
  assign br_taken    = br_taken_q;
  assign flush       = flush_q;
  assign br_count    = br_cnt_q;
  assign taken_count = taken_cnt_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Testbench for flag_branch_unit: a behavioural model pushes expected outputs
// into a scoreboard queue as each cycle's stimulus is driven; entries are
// popped and compared one time unit after the clock edge. A second instance
// with 4-bit counters shares the stimulus to exercise saturation.
module tb_flag_branch_unit;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_setflags = 1'b0;
  logic [2:0]  ex_alu_op = 3'd0;
  logic        ov = 1'b0, zr = 1'b0, neg = 1'b0;
  logic        br_valid = 1'b0;
  logic [2:0]  br_ccc = 3'd0;

  logic        flag_z, flag_v, flag_n, br_taken, flush;
  logic [15:0] br_count, taken_count;
  logic        s_flag_z, s_flag_v, s_flag_n, s_br_taken, s_flush;
  logic [3:0]  s_br_count, s_taken_count;

  flag_branch_unit #(.FLUSH_CYCLES(FC), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid),
    .ex_setflags(ex_setflags), .ex_ALUop(ex_alu_op), .ov(ov), .zr(zr), .neg(neg),
    .br_valid(br_valid), .br_ccc(br_ccc),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n), .br_taken(br_taken),
    .flush(flush), .br_count(br_count), .taken_count(taken_count)
  );

  flag_branch_unit #(.FLUSH_CYCLES(FC), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid),
    .ex_setflags(ex_setflags), .ex_ALUop(ex_alu_op), .ov(ov), .zr(zr), .neg(neg),
    .br_valid(br_valid), .br_ccc(br_ccc),
    .flag_z(s_flag_z), .flag_v(s_flag_v), .flag_n(s_flag_n), .br_taken(s_br_taken),
    .flush(s_flush), .br_count(s_br_count), .taken_count(s_taken_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic z, v, n, taken, flush;
    int   bc, tc;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int flush_seen = 0;

  // Reference model state (counts kept unsaturated, clipped per instance).
  logic m_z = 1'b0, m_v = 1'b0, m_n = 1'b0, m_fl = 1'b0;
  int   m_rem = 0, m_bc = 0, m_tc = 0;

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, push the expectation,
  // then pop and compare after the edge.
  task automatic cyc(input logic st, input logic ev, input logic sf, input logic [2:0] op,
                     input logic o, input logic z, input logic n,
                     input logic bv, input logic [2:0] cc);
    exp_t e;
    logic c;
    stall = st; ex_valid = ev; ex_setflags = sf; ex_alu_op = op;
    ov = o; zr = z; neg = n; br_valid = bv; br_ccc = cc;

    if (ev && sf && !st && !m_fl) begin
      case (op)
        3'd0, 3'd2: begin m_z = z; m_v = o; m_n = n; end
        3'd1:       ;
        default:    m_z = z;
      endcase
    end
    case (cc)
      3'd0:    c = !m_z;
      3'd1:    c = m_z;
      3'd2:    c = !m_z && !m_n;
      3'd3:    c = m_n;
      3'd4:    c = m_z || !m_n;
      3'd5:    c = m_n || m_z;
      3'd6:    c = m_v;
      default: c = 1'b1;
    endcase
    e.taken = 1'b0;
    if (!st) begin
      if (!m_fl) begin
        if (bv) begin
          m_bc++;
          if (c) begin
            m_tc++;
            e.taken = 1'b1;
            m_fl = 1'b1;
            m_rem = FC;
          end
        end
      end else begin
        m_rem--;
        if (m_rem == 0) m_fl = 1'b0;
      end
    end
    e.z = m_z; e.v = m_v; e.n = m_n; e.flush = m_fl; e.bc = m_bc; e.tc = m_tc;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("flag_z", 32'(flag_z), 32'(e.z));
    check("flag_v", 32'(flag_v), 32'(e.v));
    check("flag_n", 32'(flag_n), 32'(e.n));
    check("br_taken", 32'(br_taken), 32'(e.taken));
    check("flush", 32'(flush), 32'(e.flush));
    check("br_count", 32'(br_count), 32'(sat(e.bc, 65535)));
    check("taken_count", 32'(taken_count), 32'(sat(e.tc, 65535)));
    check("sat_br_count", 32'(s_br_count), 32'(sat(e.bc, 15)));
    check("sat_taken_count", 32'(s_taken_count), 32'(sat(e.tc, 15)));
    if (flush) flush_seen++;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    stall = 1'b0; ex_valid = 1'b0; ex_setflags = 1'b0; br_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_flags", {29'd0, flag_z, flag_v, flag_n}, 32'd0);
    check("rst_br_taken", 32'(br_taken), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_br_count", 32'(br_count), 32'd0);
    check("rst_taken_count", 32'(taken_count), 32'd0);
    m_z = 1'b0; m_v = 1'b0; m_n = 1'b0; m_fl = 1'b0;
    m_rem = 0; m_bc = 0; m_tc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "time limit");
  end

  initial begin
    #2;
    do_reset();

    // ADD overflow: V=1, Z=0, N=0.
    cyc(1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    check("add_ovf", {29'd0, flag_z, flag_v, flag_n}, 32'b010);

    // Partial mask: preload N=1,V=1 via SUB; AND writes Z only; PADDSB writes nothing.
    cyc(1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    cyc(1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    check("and_mask", {29'd0, flag_z, flag_v, flag_n}, 32'b111);
    cyc(1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    check("paddsb_mask", {29'd0, flag_z, flag_v, flag_n}, 32'b111);

    // Forwarded branch: SUB zr=1 and EQ branch in the same cycle.
    do_reset();
    flush_seen = 0;
    cyc(1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1);
    check("fwd_taken", 32'(br_taken), 32'd1);
    check("fwd_counts", {br_count, taken_count}, {16'd1, 16'd1});
    idle();
    idle();
    idle();
    check("fwd_flush_len", 32'(flush_seen), 32'd2);

    // Not taken (Z=0, EQ), then unconditional, then br_valid during FLUSH.
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    check("nt_counts", {br_count, taken_count}, {16'd1, 16'd0});
    check("nt_flush", 32'(flush), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7);
    check("flush_ignore_counts", {br_count, taken_count}, {16'd2, 16'd1});

    // Three stall cycles inside FLUSH stretch it to five cycles.
    flush_seen = 0;
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7);
    idle();
    idle();
    idle();
    check("stall_flush_len", 32'(flush_seen), 32'd5);

    // Randomised mix of flag updates, branches and stalls.
    for (int i = 0; i < 300; i++)
      cyc(logic'($urandom_range(3) == 0), logic'($urandom_range(1)), logic'($urandom_range(1)),
          3'($urandom_range(7)), logic'($urandom_range(1)), logic'($urandom_range(1)),
          logic'($urandom_range(1)), logic'($urandom_range(1)), 3'($urandom_range(7)));

    // Reset in the middle of FLUSH clears flush immediately.
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7);
    check("pre_rst_flush", 32'(flush), 32'd1);
    do_reset();
    idle();

    // Saturation: 20 taken branches.
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7);
      idle();
      idle();
    end
    check("sat4_counts", {24'd0, s_br_count, s_taken_count}, {24'd0, 4'd15, 4'd15});
    check("wide_counts", {br_count, taken_count}, {16'd20, 16'd20});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
